multicycle_control_fsm: RTL and testbench

- Multi-cycle sequencer for the RV32I core: fetch, decode, execute, memory and writeback.
- Decodes the opcode held in the instruction register and drives the ALU `instruction_type`.
- Drives the ALU operand selects, memory handshake, register-file and PC write strobes.
- Detects illegal opcodes and memory timeouts, and parks in a sticky fault state.

---
 rtl/multicycle_control_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory and writeback,
// with opcode decode, memory-wait timeout and a sticky fault state.

package multicycle_control_fsm_pkg;
    typedef enum logic [3:0] {
        R_TYPE    = 4'd0,
        I_TYPE    = 4'd1,
        LOAD_TYPE = 4'd2,
        S_TYPE    = 4'd3,
        B_TYPE    = 4'd4,
        JAL       = 4'd5,
        JALR      = 4'd6,
        LUI       = 4'd7,
        AUIPC     = 4'd8
    } instruction_types;
endpackage

module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TEST        = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic [31:0]      alu_result,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output instruction_types instruction_type,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             retire,
    output logic             fault,
    output logic [3:0]       state_dbg
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXECUTE   = 4'd2;
    localparam logic [3:0] S_MEM       = 4'd3;
    localparam logic [3:0] S_WRITEBACK = 4'd4;
    localparam logic [3:0] S_BR_TARGET = 4'd5;
    localparam logic [3:0] S_TRAP      = 4'd6;

    // A zero timeout still needs a one-bit counter to keep the vector legal.
    localparam int             CNT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(MEM_TIMEOUT);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    instruction_types cls;
    logic             illegal;
    logic             waiting;
    logic             timeout;
    logic             br_taken;
    logic             unused_instr_bits;

    assign unused_instr_bits = ^instr[31:7];

    always_comb begin
        cls     = R_TYPE;
        illegal = 1'b0;
        case (instr[6:0])
            7'b0110011: cls = R_TYPE;
            7'b0010011: cls = I_TYPE;
            7'b0000011: cls = LOAD_TYPE;
            7'b0100011: cls = S_TYPE;
            7'b1100011: cls = B_TYPE;
            7'b1101111: cls = JAL;
            7'b1100111: cls = JALR;
            7'b0110111: cls = LUI;
            7'b0010111: cls = AUIPC;
            default:    illegal = 1'b1;
        endcase
    end

    assign waiting  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign timeout  = (MEM_TIMEOUT > 0) && waiting && (cnt_q == TO_VAL);
    assign br_taken = (alu_result != 32'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: state_d = illegal ? S_TRAP : S_EXECUTE;
            S_EXECUTE: begin
                case (cls)
                    LOAD_TYPE, S_TYPE: state_d = S_MEM;
                    B_TYPE:            state_d = br_taken ? S_BR_TARGET : S_FETCH;
                    default:           state_d = S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (cls == S_TYPE) ? S_FETCH : S_WRITEBACK;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_BR_TARGET: state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    // Any state change restarts the wait count, which covers entry to FETCH and MEM.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting && (MEM_TIMEOUT > 0)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        ir_write         = 1'b0;
        reg_write        = 1'b0;
        wb_sel           = 2'd0;
        alu_a_sel        = 2'd0;
        alu_b_sel        = 1'b0;
        instruction_type = R_TYPE;
        pc_write         = 1'b0;
        pc_src           = 2'd0;
        retire           = 1'b0;
        fault            = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                S_EXECUTE: begin
                    instruction_type = cls;
                    case (cls)
                        I_TYPE, LOAD_TYPE, S_TYPE, JALR: alu_b_sel = 1'b1;
                        JAL, AUIPC: begin
                            alu_a_sel = 2'd1;
                            alu_b_sel = 1'b1;
                        end
                        LUI:     alu_a_sel = 2'd2;
                        default: ;
                    endcase
                    if ((cls == B_TYPE) && !br_taken) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                S_BR_TARGET: begin
                    instruction_type = JAL;
                    alu_a_sel        = 2'd1;
                    alu_b_sel        = 1'b1;
                    pc_write         = 1'b1;
                    pc_src           = 2'd2;
                    retire           = 1'b1;
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (cls == S_TYPE);
                    if (mem_ready && (cls == S_TYPE)) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    if (cls == LOAD_TYPE) begin
                        wb_sel = 2'd1;
                    end else if ((cls == JAL) || (cls == JALR)) begin
                        wb_sel = 2'd2;
                        pc_src = 2'd1;
                    end
                end
                S_TRAP:  fault = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_dbg = ((TEST != 0) && !reset) ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle
// output sequence, then replayed against the sequencer one cycle at a time.
module tb_multicycle_control_fsm;
    import multicycle_control_fsm_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] a_sel;
        logic       b_sel;
        logic [3:0] itype;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       retire;
        logic       fault;
    } ovec_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] ins;
        logic [31:0] alu;
        ovec_t       exp;
        ovec_t       care;
        string       tag;
    } step_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      instr = 32'd0;
    logic [31:0]      alu_result = 32'd0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, ir_write, reg_write, alu_b_sel;
    logic             pc_write, retire, fault;
    logic [1:0]       wb_sel, alu_a_sel, pc_src;
    logic [3:0]       state_dbg;
    instruction_types instruction_type;

    int    n_cmp = 0;
    int    n_fail = 0;
    step_t q[$];
    logic [31:0] cur_ins;
    logic [31:0] cur_alu;
    string cur_tag;

    multicycle_control_fsm #(.MEM_TIMEOUT(TO), .TEST(1)) dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_result(alu_result),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .instruction_type(instruction_type), .pc_write(pc_write),
        .pc_src(pc_src), .retire(retire), .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic rst, input logic rdy, input ovec_t e,
                                 input bit sel_care, input bit b_care, input string ph);
        step_t s;
        ovec_t c;
        c = '0;
        c.mem_req = 1'b1; c.mem_we = 1'b1; c.ir_write = 1'b1; c.reg_write = 1'b1;
        c.pc_write = 1'b1; c.retire = 1'b1; c.fault = 1'b1;
        if (e.reg_write) c.wb_sel = 2'b11;
        if (e.pc_write)  c.pc_src = 2'b11;
        if (sel_care) begin
            c.itype = 4'hF;
            c.a_sel = 2'b11;
            c.b_sel = b_care;
        end
        s.rst = rst; s.rdy = rdy; s.ins = cur_ins; s.alu = cur_alu;
        s.exp = e; s.care = c; s.tag = {cur_tag, "/", ph};
        q.push_back(s);
    endfunction

    function automatic void reset_step();
        push(1'b1, 1'b1, '0, 1'b0, 1'b0, "reset");
    endfunction

    function automatic void trap_seq(input int len);
        ovec_t e;
        e = '0;
        e.fault = 1'b1;
        for (int i = 0; i < len; i++) push(1'b0, rnd_bit(), e, 1'b0, 1'b0, "trap");
        reset_step();
    endfunction

    function automatic bit classify(input logic [6:0] op, output instruction_types t);
        t = R_TYPE;
        case (op)
            7'b0110011: t = R_TYPE;
            7'b0010011: t = I_TYPE;
            7'b0000011: t = LOAD_TYPE;
            7'b0100011: t = S_TYPE;
            7'b1100011: t = B_TYPE;
            7'b1101111: t = JAL;
            7'b1100111: t = JALR;
            7'b0110111: t = LUI;
            7'b0010111: t = AUIPC;
            default:    return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // Expected cycle sequence for one instruction with wf/wm not-ready cycles in FETCH/MEM.
    function automatic void add_instr(input string tag, input logic [31:0] ins,
                                      input logic [31:0] alu, input int wf, input int wm,
                                      input bit abort_mem, input int trap_len);
        instruction_types t;
        ovec_t e;
        int n;
        cur_tag = tag; cur_ins = ins; cur_alu = alu;
        e = '0; e.mem_req = 1'b1;
        n = (wf > TO) ? TO + 1 : wf;
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, e, 1'b0, 1'b0, "fetch_wait");
        if (wf > TO) begin
            trap_seq(trap_len);
            return;
        end
        e.ir_write = 1'b1;
        push(1'b0, 1'b1, e, 1'b0, 1'b0, "fetch");
        push(1'b0, rnd_bit(), '0, 1'b0, 1'b0, "decode");
        if (!classify(ins[6:0], t)) begin
            trap_seq(trap_len);
            return;
        end
        e = '0;
        e.itype = t;
        case (t)
            I_TYPE, LOAD_TYPE, S_TYPE, JALR: e.b_sel = 1'b1;
            JAL, AUIPC: begin e.a_sel = 2'd1; e.b_sel = 1'b1; end
            LUI: e.a_sel = 2'd2;
            default: ;
        endcase
        if (t == B_TYPE && alu == 32'd0) begin
            e.pc_write = 1'b1; e.retire = 1'b1; e.pc_src = 2'd0;
            push(1'b0, rnd_bit(), e, 1'b1, 1'b1, "exec_nt");
            return;
        end
        push(1'b0, rnd_bit(), e, 1'b1, (t != LUI), "exec");
        if (t == B_TYPE) begin
            e = '0;
            e.itype = JAL; e.a_sel = 2'd1; e.b_sel = 1'b1;
            e.pc_write = 1'b1; e.pc_src = 2'd2; e.retire = 1'b1;
            push(1'b0, rnd_bit(), e, 1'b1, 1'b1, "br_target");
            return;
        end
        if (t == LOAD_TYPE || t == S_TYPE) begin
            e = '0; e.mem_req = 1'b1; e.mem_we = (t == S_TYPE);
            if (abort_mem) begin
                push(1'b0, 1'b0, e, 1'b0, 1'b0, "mem_wait");
                reset_step();
                return;
            end
            n = (wm > TO) ? TO + 1 : wm;
            for (int i = 0; i < n; i++) push(1'b0, 1'b0, e, 1'b0, 1'b0, "mem_wait");
            if (wm > TO) begin
                trap_seq(trap_len);
                return;
            end
            if (t == S_TYPE) begin
                e.pc_write = 1'b1; e.retire = 1'b1; e.pc_src = 2'd0;
                push(1'b0, 1'b1, e, 1'b0, 1'b0, "mem_store");
                return;
            end
            push(1'b0, 1'b1, e, 1'b0, 1'b0, "mem_load");
        end
        e = '0;
        e.reg_write = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1;
        if (t == LOAD_TYPE) e.wb_sel = 2'd1;
        if (t == JAL || t == JALR) begin
            e.wb_sel = 2'd2;
            e.pc_src = 2'd1;
        end
        push(1'b0, rnd_bit(), e, 1'b0, 1'b0, "writeback");
    endfunction

    initial begin
        logic [6:0]  ops [9];
        logic [31:0] r;
        logic [6:0]  op;
        int          cyc;
        step_t       s;
        ovec_t       obs;
        logic [$bits(ovec_t)-1:0] ov, ev, cv;

        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        cur_tag = "init"; cur_ins = 32'd0; cur_alu = 32'd0;
        reset_step();
        reset_step();
        add_instr("r_add",     32'h002081B3, 32'h5, 0, 0, 1'b0, 3);
        add_instr("lw_wait",   32'h0000A183, 32'h0, 3, 3, 1'b0, 3);
        add_instr("beq_taken", 32'h00208463, 32'h00FFFFFF, 0, 0, 1'b0, 3);
        add_instr("beq_nt",    32'h00208463, 32'h0, 0, 0, 1'b0, 3);
        add_instr("jal",       32'h008000EF, 32'h0, 0, 0, 1'b0, 3);
        add_instr("illegal",   32'h0000007F, 32'h0, 0, 0, 1'b0, 20);
        add_instr("fetch_to",  32'h002081B3, 32'h0, 10, 0, 1'b0, 3);
        add_instr("fetch_edge", 32'h002081B3, 32'h0, 4, 0, 1'b0, 3);
        add_instr("sw_abort",  32'h0020A023, 32'h0, 0, 0, 1'b1, 3);
        add_instr("lui",       32'h000010B7, 32'h0, 1, 0, 1'b0, 3);
        add_instr("auipc",     32'h00001097, 32'h0, 0, 0, 1'b0, 3);
        add_instr("jalr",      32'h000080E7, 32'h0, 0, 0, 1'b0, 3);
        add_instr("addi",      32'h00108093, 32'h0, 2, 0, 1'b0, 3);
        add_instr("sw_edge",   32'h0020A023, 32'h0, 0, 4, 1'b0, 3);
        add_instr("lw_to",     32'h0000A183, 32'h0, 0, 7, 1'b0, 4);
        for (int k = 0; k < 80; k++) begin
            r = $urandom();
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 15) == 0) op = r[6:0];
            add_instr($sformatf("rnd%0d", k), {r[31:7], op},
                      ($urandom_range(0, 1) == 1) ? $urandom() : 32'd0,
                      ($urandom_range(0, 11) == 0) ? 5 : $urandom_range(0, 3),
                      ($urandom_range(0, 11) == 0) ? 6 : $urandom_range(0, 4),
                      1'b0, $urandom_range(2, 5));
        end

        cyc = 0;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            s = q.pop_front();
            reset = s.rst; mem_ready = s.rdy; instr = s.ins; alu_result = s.alu;
            @(negedge clk);
            obs = '0;
            obs.mem_req = mem_req; obs.mem_we = mem_we; obs.ir_write = ir_write;
            obs.reg_write = reg_write; obs.wb_sel = wb_sel; obs.a_sel = alu_a_sel;
            obs.b_sel = alu_b_sel; obs.itype = instruction_type; obs.pc_write = pc_write;
            obs.pc_src = pc_src; obs.retire = retire; obs.fault = fault;
            ov = obs & s.care; ev = s.exp & s.care; cv = s.care;
            n_cmp++;
            assert (ov === ev) else begin
                n_fail++;
                $error("FAIL %s cyc=%0d observed=%h expected=%h care=%h", s.tag, cyc, ov, ev, cv);
            end
            if (s.rst) begin
                n_cmp++;
                assert (state_dbg === 4'd0) else begin
                    n_fail++;
                    $error("FAIL %s_state_dbg cyc=%0d observed=%0d expected=0", s.tag, cyc, state_dbg);
                end
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
